nexys_starship_alien_spawner: RTL and testbench

Consumes the per-direction random strobes from the starship PRNG and turns them into alien threats in four slots: top, bottom, left and right.
Each slot follows a spawn, live, then cooldown lifecycle. A live alien can be cleared by a player shot. An alien left alive too long hits the ship.
The block also tracks lives, score and game-over state for the display and VGA stages downstream.

---
 rtl/nexys_starship_alien_spawner.sv | 179 +++++++++++++++++
 tb/tb_nexys_starship_alien_spawner.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_alien_spawner.sv
// Four-slot alien spawner: spawn/live/cooldown lifecycle per slot, plus lives, score and game-over tracking.
// Optional macro SPAWNER_DIFFICULTY_EN shortens alien lifetime as the score grows.
module nexys_starship_alien_spawner #(
   parameter int unsigned TIMEOUT  = 1000,
   parameter int unsigned COOLDOWN = 50,
   parameter int unsigned LIVES    = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Start,
   input  logic       Tick,
   input  logic       top_random,
   input  logic       btm_random,
   input  logic       left_random,
   input  logic       right_random,
   input  logic       TR_random,
   input  logic       BR_random,
   input  logic       LR_random,
   input  logic       RR_random,
   input  logic [3:0] Shoot,
   output logic [3:0] alien_present,
   output logic [3:0] alien_armored,
   output logic       hit,
   output logic [1:0] lives,
   output logic [7:0] score,
   output logic       game_over
);

   typedef enum logic [1:0] {G_IDLE, G_PLAY, G_OVER} game_t;
   typedef enum logic [1:0] {S_EMPTY, S_ACTIVE, S_COOL} slot_t;

   localparam logic [15:0] TIMEOUT_L  = 16'(TIMEOUT);
   localparam logic [15:0] COOLDOWN_L = 16'(COOLDOWN);
   localparam logic [1:0]  LIVES_L    = 2'(LIVES);

   game_t       game_q;
   slot_t       slot_q  [4];
   logic [15:0] timer_q [4];
   logic [3:0]  armored_q;
   logic        hit_q;
   logic [1:0]  lives_q;
   logic [7:0]  score_q;

   logic [3:0]  spawn, arm_in, kill, tout;
   logic [2:0]  n_kill, n_tout;
   logic [8:0]  score_sum;
   logic [7:0]  score_d;
   logic [1:0]  lives_d;
   logic [15:0] load;

   assign spawn  = {right_random, left_random, btm_random, top_random};
   assign arm_in = {RR_random, LR_random, BR_random, TR_random};

`ifdef SPAWNER_DIFFICULTY_EN
   logic [1:0]  shift;
   logic [15:0] load_sh;
   assign shift   = (score_q[7:6] != 2'd0) ? 2'd3 : score_q[5:4];
   assign load_sh = TIMEOUT_L >> shift;
   assign load    = (load_sh == 16'd0) ? 16'd1 : load_sh;
`else
   assign load = TIMEOUT_L;
`endif

   // A non-armored shot pre-empts the timeout; an armored shot only strips armor.
   always_comb begin
      kill   = '0;
      tout   = '0;
      n_kill = '0;
      n_tout = '0;
      for (int i = 0; i < 4; i++) begin
         if (game_q == G_PLAY && lives_q != 2'd0 && slot_q[i] == S_ACTIVE) begin
            if (Shoot[i] && !armored_q[i])
               kill[i] = 1'b1;
            else if (Tick && timer_q[i] == 16'd1)
               tout[i] = 1'b1;
         end
         n_kill = n_kill + 3'(kill[i]);
         n_tout = n_tout + 3'(tout[i]);
      end
      score_sum = {1'b0, score_q} + {6'd0, n_kill};
      score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
      lives_d   = ({1'b0, lives_q} <= n_tout) ? 2'd0 : 2'({1'b0, lives_q} - n_tout);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         game_q    <= G_IDLE;
         armored_q <= '0;
         hit_q     <= 1'b0;
         lives_q   <= LIVES_L;
         score_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            slot_q[i]  <= S_EMPTY;
            timer_q[i] <= '0;
         end
      end else begin
         case (game_q)
            G_PLAY: begin
               if (lives_q == 2'd0) begin
                  game_q    <= G_OVER;
                  hit_q     <= 1'b0;
                  armored_q <= '0;
                  for (int i = 0; i < 4; i++) begin
                     slot_q[i]  <= S_EMPTY;
                     timer_q[i] <= '0;
                  end
               end else begin
                  hit_q   <= |tout;
                  lives_q <= lives_d;
                  score_q <= score_d;
                  for (int i = 0; i < 4; i++) begin
                     case (slot_q[i])
                        S_EMPTY: begin
                           if (Tick && spawn[i]) begin
                              slot_q[i]    <= S_ACTIVE;
                              timer_q[i]   <= load;
                              armored_q[i] <= arm_in[i];
                           end
                        end
                        S_ACTIVE: begin
                           if (kill[i] || tout[i]) begin
                              slot_q[i]    <= S_COOL;
                              timer_q[i]   <= COOLDOWN_L;
                              armored_q[i] <= 1'b0;
                           end else begin
                              if (Shoot[i])
                                 armored_q[i] <= 1'b0;
                              if (Tick)
                                 timer_q[i] <= timer_q[i] - 16'd1;
                           end
                        end
                        S_COOL: begin
                           if (Tick) begin
                              if (timer_q[i] == 16'd1) begin
                                 slot_q[i]  <= S_EMPTY;
                                 timer_q[i] <= '0;
                              end else begin
                                 timer_q[i] <= timer_q[i] - 16'd1;
                              end
                           end
                        end
                        default: begin
                           slot_q[i]  <= S_EMPTY;
                           timer_q[i] <= '0;
                        end
                     endcase
                  end
               end
            end
            default: begin
               hit_q     <= 1'b0;
               armored_q <= '0;
               for (int i = 0; i < 4; i++) begin
                  slot_q[i]  <= S_EMPTY;
                  timer_q[i] <= '0;
               end
               if (Start) begin
                  game_q  <= G_PLAY;
                  lives_q <= LIVES_L;
                  score_q <= '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      alien_present = '0;
      for (int i = 0; i < 4; i++)
         alien_present[i] = (slot_q[i] == S_ACTIVE);
   end

   assign alien_armored = armored_q;
   assign hit           = hit_q;
   assign lives         = lives_q;
   assign score         = score_q;
   assign game_over     = (game_q == G_OVER);

endmodule

// File: tb/tb_nexys_starship_alien_spawner.sv
// Self-checking bench for nexys_starship_alien_spawner: directed vector table, corner sequences,
// and randomized traffic compared against a lifetime-counting reference model.
module tb_nexys_starship_alien_spawner;

   localparam int TIMEOUT  = 4;
   localparam int COOLDOWN = 2;
   localparam int LIVES    = 3;
   localparam int MD_IDLE  = 0;
   localparam int MD_PLAY  = 1;
   localparam int MD_OVER  = 2;

   logic       Clk = 1'b0;
   logic       Reset, Start, Tick;
   logic       top_random, btm_random, left_random, right_random;
   logic       TR_random, BR_random, LR_random, RR_random;
   logic [3:0] Shoot;
   logic [3:0] alien_present, alien_armored;
   logic       hit, game_over;
   logic [1:0] lives;
   logic [7:0] score;

   nexys_starship_alien_spawner #(.TIMEOUT(TIMEOUT), .COOLDOWN(COOLDOWN), .LIVES(LIVES)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .Tick(Tick),
      .top_random(top_random), .btm_random(btm_random),
      .left_random(left_random), .right_random(right_random),
      .TR_random(TR_random), .BR_random(BR_random),
      .LR_random(LR_random), .RR_random(RR_random),
      .Shoot(Shoot), .alien_present(alien_present), .alien_armored(alien_armored),
      .hit(hit), .lives(lives), .score(score), .game_over(game_over)
   );

   always #5 Clk = ~Clk;

   logic [19:0] dut_out;
   assign dut_out = {alien_present, alien_armored, hit, lives, score, game_over};

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: each live alien carries its remaining ticks of life,
   // each cooling slot its remaining ticks of cooldown.
   int m_mode, m_lives, m_score;
   bit m_hit;
   bit m_live [4];
   bit m_arm  [4];
   int m_ttl  [4];
   int m_cool [4];

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_live[i] = 0; m_arm[i] = 0; m_ttl[i] = 0; m_cool[i] = 0;
      end
   endtask

   task automatic model_reset();
      m_mode = MD_IDLE; m_lives = LIVES; m_score = 0; m_hit = 0;
      model_clear();
   endtask

   function automatic int model_load();
      int l;
      l = TIMEOUT;
`ifdef SPAWNER_DIFFICULTY_EN
      begin
         int s;
         s = m_score / 16;
         if (s > 3) s = 3;
         l = TIMEOUT >> s;
         if (l < 1) l = 1;
      end
`endif
      return l;
   endfunction

   task automatic model_step(input bit st, input bit tk, input bit [3:0] sp,
                             input bit [3:0] ar, input bit [3:0] sh);
      int kills, touts, ld;
      if (m_mode == MD_PLAY && m_lives == 0) begin
         m_mode = MD_OVER; m_hit = 0; model_clear();
         return;
      end
      if (m_mode != MD_PLAY) begin
         m_hit = 0; model_clear();
         if (st) begin m_mode = MD_PLAY; m_lives = LIVES; m_score = 0; end
         return;
      end
      kills = 0; touts = 0;
      ld = model_load();
      for (int i = 0; i < 4; i++) begin
         if (m_live[i]) begin
            if (sh[i] && !m_arm[i]) begin
               m_live[i] = 0; m_cool[i] = COOLDOWN; kills++;
            end else begin
               if (sh[i]) m_arm[i] = 0;
               if (tk) begin
                  m_ttl[i]--;
                  if (m_ttl[i] == 0) begin
                     m_live[i] = 0; m_arm[i] = 0; m_cool[i] = COOLDOWN; touts++;
                  end
               end
            end
         end else if (m_cool[i] > 0) begin
            if (tk) m_cool[i]--;
         end else if (tk && sp[i]) begin
            m_live[i] = 1; m_ttl[i] = ld; m_arm[i] = ar[i];
         end
      end
      m_score = (m_score + kills > 255) ? 255 : m_score + kills;
      m_lives = (m_lives - touts < 0) ? 0 : m_lives - touts;
      m_hit   = (touts > 0);
   endtask

   function automatic logic [19:0] model_out();
      logic [3:0] p, a;
      for (int i = 0; i < 4; i++) begin
         p[i] = m_live[i];
         a[i] = m_live[i] & m_arm[i];
      end
      return {p, a, m_hit, 2'(m_lives), 8'(m_score), (m_mode == MD_OVER)};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apply(input bit st, input bit tk, input bit [3:0] sp,
                        input bit [3:0] ar, input bit [3:0] sh);
      Start = st; Tick = tk;
      {right_random, left_random, btm_random, top_random} = sp;
      {RR_random, LR_random, BR_random, TR_random} = ar;
      Shoot = sh;
      @(posedge Clk);
      model_step(st, tk, sp, ar, sh);
      @(negedge Clk);
      chk("model", int'(dut_out), int'(model_out()));
   endtask

   typedef struct {
      bit st; bit tk; bit [3:0] sp; bit [3:0] ar; bit [3:0] sh;
      bit [3:0] pres; bit [3:0] arm; bit hit; int lives; int score; bit over;
   } vec_t;

   vec_t tbl [20];

   // Spawn all four, let every one expire, and check the single hit and the OVER entry.
   task automatic all_timeout();
      apply(0, 1, 4'hF, 4'h0, 4'h0);
      chk("all_spawn", int'(alien_present), 4'hF);
      for (int t = 0; t < TIMEOUT - 1; t++) apply(0, 1, 4'h0, 4'h0, 4'h0);
      apply(0, 1, 4'h0, 4'h0, 4'h0);
      chk("all_hit", int'(hit), 1);
      chk("all_lives", int'(lives), 0);
      chk("all_pres", int'(alien_present), 0);
      apply(0, 0, 4'h0, 4'h0, 4'h0);
      chk("all_hit_pulse", int'(hit), 0);
      chk("all_over", int'(game_over), 1);
      apply(0, 1, 4'hF, 4'h0, 4'h0);
      chk("over_no_spawn", int'(alien_present), 0);
      apply(1, 0, 4'h0, 4'h0, 4'h0);
      chk("restart_lives", int'(lives), LIVES);
      chk("restart_score", int'(score), 0);
      chk("restart_over", int'(game_over), 0);
   endtask

   logic [19:0] exp_rst;

   initial begin
      exp_rst = {4'h0, 4'h0, 1'b0, 2'(LIVES), 8'd0, 1'b0};
      tbl[0]  = '{1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 0};
      tbl[1]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 0, 3, 0, 0};
      tbl[2]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 0, 3, 0, 0};
      tbl[3]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 0, 3, 0, 0};
      tbl[4]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 0, 3, 0, 0};
      tbl[5]  = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 2, 0, 0};
      tbl[6]  = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 0, 0};
      tbl[7]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 0, 0};
      tbl[8]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 0, 0};
      tbl[9]  = '{0, 1, 4'h1, 4'h0, 4'h0, 4'h1, 4'h0, 0, 2, 0, 0};
      tbl[10] = '{0, 1, 4'h4, 4'h4, 4'h0, 4'h5, 4'h4, 0, 2, 0, 0};
      tbl[11] = '{0, 0, 4'h0, 4'h0, 4'h4, 4'h5, 4'h0, 0, 2, 0, 0};
      tbl[12] = '{0, 0, 4'h0, 4'h0, 4'h0, 4'h5, 4'h0, 0, 2, 0, 0};
      tbl[13] = '{0, 0, 4'h0, 4'h0, 4'h4, 4'h1, 4'h0, 0, 2, 1, 0};
      tbl[14] = '{0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 2, 2, 0};
      tbl[15] = '{0, 0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 0, 2, 2, 0};
      tbl[16] = '{0, 0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 0, 2, 2, 0};
      tbl[17] = '{0, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 2, 0};
      tbl[18] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 2, 0};
      tbl[19] = '{0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 2, 2, 0};

      Reset = 1; Start = 0; Tick = 0; Shoot = 0;
      {top_random, btm_random, left_random, right_random} = 4'h0;
      {TR_random, BR_random, LR_random, RR_random} = 4'h0;
      model_reset();
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset_state", int'(dut_out), int'(exp_rst));
      Reset = 0;

      apply(0, 1, 4'hF, 4'hF, 4'h0);
      chk("idle_no_spawn", int'(alien_present), 0);

      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].st, tbl[i].tk, tbl[i].sp, tbl[i].ar, tbl[i].sh);
         chk($sformatf("vec%0d", i), int'(dut_out),
             int'({tbl[i].pres, tbl[i].arm, tbl[i].hit, 2'(tbl[i].lives),
                   8'(tbl[i].score), tbl[i].over}));
      end

      // Lives 2 saturates to 0 on four timeouts, then a full 3-life round.
      all_timeout();
      all_timeout();

      // Kill on the final timeout tick wins over the timeout.
      apply(0, 1, 4'h2, 4'h0, 4'h0);
      for (int t = 0; t < TIMEOUT - 1; t++) apply(0, 1, 4'h0, 4'h0, 4'h0);
      apply(0, 1, 4'h0, 4'h0, 4'h2);
      chk("race_score", int'(score), 1);
      chk("race_hit", int'(hit), 0);
      chk("race_lives", int'(lives), 3);
      apply(0, 1, 4'h0, 4'h0, 4'h0);
      apply(0, 1, 4'h0, 4'h0, 4'h0);
      apply(0, 1, 4'h2, 4'h2, 4'h0);
      for (int t = 0; t < TIMEOUT - 1; t++) apply(0, 1, 4'h0, 4'h0, 4'h0);
      apply(0, 1, 4'h0, 4'h0, 4'h2);
      chk("race_arm_hit", int'(hit), 1);
      chk("race_arm_lives", int'(lives), 2);
      chk("race_arm_pres", int'(alien_present), 0);
      apply(1, 0, 4'h0, 4'h0, 4'h0);
      chk("start_in_play_score", int'(score), 1);
      chk("start_in_play_lives", int'(lives), 2);
      apply(0, 1, 4'h0, 4'h0, 4'h0);
      apply(0, 1, 4'h0, 4'h0, 4'h0);

      // Drive score past 255 in batches of four kills.
      for (int r = 0; r < 64; r++) begin
         apply(0, 1, 4'hF, 4'h0, 4'h0);
         apply(0, 0, 4'h0, 4'h0, 4'hF);
         apply(0, 1, 4'h0, 4'h0, 4'h0);
         apply(0, 1, 4'h0, 4'h0, 4'h0);
      end
      chk("score_sat", int'(score), 255);
      apply(0, 1, 4'h1, 4'h0, 4'h0);
      apply(0, 0, 4'h0, 4'h0, 4'h1);
      chk("score_sat_kill", int'(score), 255);
      chk("score_sat_pres", int'(alien_present), 0);

      for (int n = 0; n < 1500; n++) begin
         if (n == 700) begin
            Reset = 1;
            #2;
            chk("reset_midgame", int'(dut_out), int'(exp_rst));
            model_reset();
            @(negedge Clk);
            Reset = 0;
         end
         apply($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
               4'($urandom), 4'($urandom),
               ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
